// File: rtl/hazard_scoreboard_if.sv
// ID-stage to stall-unit bundle: decoded operand/destination info in, stall controls out.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int LAT_W = 3,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [AW-1:0]    id_ra;
  logic [AW-1:0]    id_rb;
  logic             id_use_ra;
  logic             id_use_rb;
  logic             id_early;
  logic             id_regwr;
  logic [AW-1:0]    id_rw;
  logic [LAT_W-1:0] id_lat;
  logic             id_md_start;
  logic             id_md_use;
  logic             flush;
  logic             stall;
  logic             stall_ra;
  logic             stall_rb;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_early,
           id_regwr, id_rw, id_lat, id_md_start, id_md_use, flush,
    input  stall, stall_ra, stall_rb, md_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_early,
           id_regwr, id_rw, id_lat, id_md_start, id_md_use, flush,
    output stall, stall_ra, stall_rb, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage stall unit: per-register forwarding countdowns plus a mult/div occupancy
// counter drive a single pipeline stall and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int LAT_W  = 3,
  parameter int MD_LAT = 32,
  parameter int MDC_W  = 6,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);

  logic [LAT_W-1:0] cnt [1:NREG-1];
  logic [MDC_W-1:0] md_cnt;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [LAT_W-1:0] cnt_a;
  logic [LAT_W-1:0] cnt_b;
  logic             haz_a;
  logic             haz_b;
  logic             md_hz;
  logic             id_live;
  logic             stall_ra_c;
  logic             stall_rb_c;
  logic             stall_c;
  logic             issue;
  logic             wr_en;

  // r0 has no entry and indices at or beyond NREG never match, so both read as zero.
  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    for (int r = 1; r < NREG; r++) begin
      if (int'(sb.id_ra) == r) cnt_a = cnt[r];
      if (int'(sb.id_rb) == r) cnt_b = cnt[r];
    end
  end

  // A count of 1 is covered by EX-to-EX forwarding unless the operand is needed in ID.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    if (sb.id_use_ra)
      haz_a = sb.id_early ? (cnt_a != '0) : (cnt_a > LAT_W'(1));
    if (sb.id_use_rb)
      haz_b = sb.id_early ? (cnt_b != '0) : (cnt_b > LAT_W'(1));
  end

  always_comb begin
    id_live    = sb.id_valid && !sb.flush && !rst;
    md_hz      = (md_cnt != '0) && (sb.id_md_use || sb.id_md_start);
    stall_ra_c = id_live && haz_a;
    stall_rb_c = id_live && haz_b;
    stall_c    = stall_ra_c || stall_rb_c || (id_live && md_hz);
    issue      = sb.id_valid && !stall_c && !sb.flush;
    wr_en      = issue && sb.id_regwr && (sb.id_rw != '0) && (sb.id_lat != '0);
  end

  // A newly issued writer replaces whatever count an older producer left behind.
  always_ff @(posedge clk) begin
    for (int r = 1; r < NREG; r++) begin
      if (rst)
        cnt[r] <= '0;
      else if (wr_en && int'(sb.id_rw) == r)
        cnt[r] <= sb.id_lat;
      else if (cnt[r] != '0)
        cnt[r] <= cnt[r] - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      md_cnt <= '0;
    else if (issue && sb.id_md_start)
      md_cnt <= MDC_W'(MD_LAT);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - MDC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_c && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign sb.stall     = stall_c;
  assign sb.stall_ra  = stall_ra_c;
  assign sb.stall_rb  = stall_rb_c;
  assign sb.md_busy   = (md_cnt != '0);
  assign sb.stall_cnt = stall_cnt_q;

endmodule
